gpio_input_responder: RTL
=========================

Name: gpio_input_responder

Overview:
- Memory-mapped input peripheral for the multicycle RISC-V SOC; the input-side counterpart of the active-low LED outputs (ledr_n/ledg_n).
- Samples active-low button/switch pins and synchronizes and debounces them.
- Latches rising-edge (press) events and answers CPU load/store requests on the SOC memory bus with a single-cycle-response handshake.
- Drives an interrupt line to the core.

Parameters:
- N_INPUTS, 2, number of active-low input pins (1..32).
- DEBOUNCE_CYCLES, 12000, consecutive stable cycles required before the debounced state changes (1 ms at 12 MHz); minimum 2.
- CNT_W, 14, debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock.
- reset_n  input  1  asynchronous active-low reset.
- btn_n  input  N_INPUTS  raw asynchronous active-low pins.
- mem_valid  input  1  request valid; CPU holds it and the other request fields stable until mem_ready.
- mem_sel  input  1  address decode hit for this peripheral.
- mem_addr  input  5  byte offset within the peripheral window; bits [1:0] ignored.
- mem_wdata  input  32  store data.
- mem_wstrb  input  4  byte strobes; all zero means read.
- mem_rdata  output  32  read data, valid while mem_ready=1.
- mem_ready  output  1  one-cycle response pulse.
- irq  output  1  level interrupt.

Behaviour:
- Reset values (all asynchronous on reset_n=0):
  - Synchronizer flops = all ones (pins released).
  - stable, edge, irq_en, fall registers = 0.
  - Counters = 0.
  - mem_ready = 0, mem_rdata = 0, irq = 0.
  - FSM = IDLE.
- Synchronizer: 2-flop per bit on btn_n. sync = inverted second stage, so 1 = pressed.
- Debounce, per bit:
  - If sync == stable, counter is cleared to 0.
  - Otherwise the counter increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while sync != stable, stable takes sync and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Latency: a clean pin transition reaches stable 2+DEBOUNCE_CYCLES clock edges after it is first sampled.
- Edge capture:
  - edge[i] is set on the cycle stable[i] goes 0->1 and stays set until cleared by software.
  - If a set and a W1C of the same bit land in the same cycle, the set wins.
- Register map (word offsets):
  - 0x00 DATA: RO, stable, zero-extended.
  - 0x04 EDGE: read returns edge; write-1-to-clear.
  - 0x08 IRQ_EN: RW, N_INPUTS bits.
  - 0x0C RAW: RO, sync.
  - 0x10 FALL: see Optional Feature.
  - 0x14..0x1C: read 0, writes ignored, still acknowledged.
- Bus FSM, two states:
  - IDLE: if mem_valid & mem_sel, perform the write (when any mem_wstrb bit is set, full-word effect), capture the read data into mem_rdata, go to RESP.
  - RESP: mem_ready=1 for exactly this cycle, then return to IDLE. mem_valid is not sampled in RESP.
  - Response latency is 1 cycle; back-to-back accesses take 2 cycles each.
- mem_rdata holds its last value while mem_ready=0.
- Reads sample register state at the IDLE cycle. A read of EDGE and a same-cycle hardware set are resolved as: read returns the pre-set value, and the set is kept.
- irq = registered |(edge & irq_en), i.e. one cycle after the edge or enable changes.
- Reset mid-transaction aborts it: mem_ready stays 0, and the CPU must reissue the request.

Optional Feature:
- Macro: GPIO_FALLING_EDGE_EN.
- Defined:
  - FALL register at 0x10; bit i is set on stable[i] 1->0 (release), W1C, same set-wins rule as EDGE.
  - irq = |((edge | fall) & irq_en).
- Undefined:
  - 0x10 reads 0, writes are ignored, no fall logic is synthesized.
  - irq uses edge only.

Test Plan:
- Bench uses DEBOUNCE_CYCLES=4, N_INPUTS=2.
- Reset: hold reset_n=0 with btn_n=2'b00 -> mem_ready=0, irq=0; after release, a read of 0x00 returns 0 until debounce completes.
- Clean press: btn_n[0] 1->0 and held -> DATA reads 0x1 exactly 6 edges after first sample; EDGE reads 0x1; with IRQ_EN=0x1, irq=1 one cycle after the edge sets.
- Glitch: btn_n[1] low for 3 cycles then high -> DATA stays 0x0, EDGE stays 0x0, RAW shows 0x2 during the glitch.
- W1C collision: EDGE=0x1, write 0x1 to 0x04 in the same cycle stable[1] rises -> EDGE reads 0x2; a subsequent write of 0x3 -> EDGE reads 0x0 and irq drops.
- Handshake: mem_valid held across 3 back-to-back requests (read 0x08, write 0x08=0x3, read 0x1C) -> mem_ready pulses once per request, 1 cycle after acceptance; reads return 0x0, (write acknowledged), 0x0; IRQ_EN reads 0x3 afterwards.
- Falling edge: press then release btn_n[0] -> with GPIO_FALLING_EDGE_EN, FALL reads 0x1; without it, 0x10 reads 0x0 and irq does not assert on release.

Source files
------------

// File: rtl/gpio_input_responder.sv
// ---------------------------------------------------------------------------
// gpio_input_responder
//
// Memory-mapped input peripheral for the multicycle RISC-V SOC. It samples
// active-low button/switch pins, synchronizes and debounces them, and latches
// press (rising) events. It also answers CPU load/store requests with a
// single-cycle response pulse and drives a level interrupt to the core.
//
// Optional feature macro: GPIO_FALLING_EDGE_EN
//   defined   -> FALL register at 0x10 latches release events (W1C), and
//                FALL bits also raise the interrupt.
//   undefined -> 0x10 reads 0, writes to it are ignored, and no release
//                logic is built.
//
// Parameters:
//   N_INPUTS        number of active-low input pins (1..32)
//   DEBOUNCE_CYCLES consecutive disagreeing cycles before the debounced
//                   state follows the pin (minimum 2)
//   CNT_W           debounce counter width, 2**CNT_W > DEBOUNCE_CYCLES
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   btn_n      raw asynchronous active-low pins
//   mem_valid  request valid, held stable by the CPU until mem_ready
//   mem_sel    address decode hit for this peripheral
//   mem_addr   byte offset within the window (bits [1:0] ignored)
//   mem_wdata  store data
//   mem_wstrb  byte strobes, all zero means read
//   mem_rdata  read data, valid while mem_ready=1, held otherwise
//   mem_ready  one-cycle response pulse
//   irq        level interrupt, registered
//
// Register map (word offsets):
//   0x00 DATA    RO   debounced state (1 = pressed)
//   0x04 EDGE    W1C  latched press events
//   0x08 IRQ_EN  RW   interrupt enables
//   0x0C RAW     RO   synchronized, undebounced state
//   0x10 FALL    W1C  latched release events (optional feature)
//   0x14..0x1C        read 0, writes ignored, still acknowledged
// ---------------------------------------------------------------------------
module gpio_input_responder #(
  parameter int N_INPUTS        = 2,
  parameter int DEBOUNCE_CYCLES = 12000,
  parameter int CNT_W           = 14
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [N_INPUTS-1:0] btn_n,
  input  logic                mem_valid,
  input  logic                mem_sel,
  input  logic [4:0]          mem_addr,
  input  logic [31:0]         mem_wdata,
  input  logic [3:0]          mem_wstrb,
  output logic [31:0]         mem_rdata,
  output logic                mem_ready,
  output logic                irq
);

  // Word index decode (mem_addr[4:2]).
  localparam logic [2:0] W_DATA  = 3'd0;
  localparam logic [2:0] W_EDGE  = 3'd1;
  localparam logic [2:0] W_IRQEN = 3'd2;
  localparam logic [2:0] W_RAW   = 3'd3;
  localparam logic [2:0] W_FALL  = 3'd4;

  // Last count value before the debounced state is allowed to follow.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    S_IDLE,
    S_RESP
  } state_e;

  // -------------------------------------------------------------------------
  // Two-flop synchronizer. Reset to all ones so released pins do not look
  // like presses while coming out of reset.
  // -------------------------------------------------------------------------
  logic [N_INPUTS-1:0] sync1_q;
  logic [N_INPUTS-1:0] sync2_q;
  logic [N_INPUTS-1:0] sync_w;   // 1 = pressed

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
    end
  end

  assign sync_w = ~sync2_q;

  // -------------------------------------------------------------------------
  // Per-bit debounce. The counter measures how long sync has disagreed with
  // the debounced state; any agreement resets it, so a glitch shorter than
  // DEBOUNCE_CYCLES never reaches the debounced state.
  // -------------------------------------------------------------------------
  logic [N_INPUTS-1:0] stable_q;  // current debounced state
  logic [N_INPUTS-1:0] stable_d;  // debounced state after this edge

  for (genvar gi = 0; gi < N_INPUTS; gi++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             bit_q;
    logic             bit_d;

    always_comb begin
      cnt_d = cnt_q;
      bit_d = bit_q;
      if (sync_w[gi] == bit_q) begin
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        bit_d = sync_w[gi];
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q <= '0;
        bit_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        bit_q <= bit_d;
      end
    end

    assign stable_q[gi] = bit_q;
    assign stable_d[gi] = bit_d;
  end

  // Press events are detected on the next-state value so that EDGE is set
  // on the same clock edge that DATA changes.
  logic [N_INPUTS-1:0] rise_w;
  assign rise_w = stable_d & ~stable_q;

  // -------------------------------------------------------------------------
  // Software-visible state
  // -------------------------------------------------------------------------
  logic [N_INPUTS-1:0] edge_q,   edge_d;
  logic [N_INPUTS-1:0] irq_en_q, irq_en_d;
  logic [N_INPUTS-1:0] edge_clr_w;
  logic [N_INPUTS-1:0] pend_w;     // sources that may raise the interrupt
  logic                irq_q,    irq_d;
  state_e              state_q,  state_d;
  logic [31:0]         rdata_q,  rdata_d;
  logic [31:0]         rd_word_w;

`ifdef GPIO_FALLING_EDGE_EN
  logic [N_INPUTS-1:0] fall_q, fall_d;
  logic [N_INPUTS-1:0] fall_clr_w;
  logic [N_INPUTS-1:0] fall_set_w;

  assign fall_set_w = ~stable_d & stable_q;
  // Set wins over a same-cycle W1C, matching EDGE.
  assign fall_d     = (fall_q & ~fall_clr_w) | fall_set_w;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign pend_w = edge_q | fall_q;
`else
  assign pend_w = edge_q;
`endif

  // Read mux over current (pre-edge) register state, so a read of EDGE that
  // coincides with a hardware set returns the value before the set.
  always_comb begin
    rd_word_w = '0;
    case (mem_addr[4:2])
      W_DATA:  rd_word_w[N_INPUTS-1:0] = stable_q;
      W_EDGE:  rd_word_w[N_INPUTS-1:0] = edge_q;
      W_IRQEN: rd_word_w[N_INPUTS-1:0] = irq_en_q;
      W_RAW:   rd_word_w[N_INPUTS-1:0] = sync_w;
`ifdef GPIO_FALLING_EDGE_EN
      W_FALL:  rd_word_w[N_INPUTS-1:0] = fall_q;
`endif
      default: rd_word_w = '0;
    endcase
  end

  // -------------------------------------------------------------------------
  // Bus FSM. A request is taken in IDLE; the following cycle is RESP, where
  // mem_ready is high and mem_valid is ignored, giving 2 cycles per access.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    rdata_d    = rdata_q;
    irq_en_d   = irq_en_q;
    edge_clr_w = '0;
`ifdef GPIO_FALLING_EDGE_EN
    fall_clr_w = '0;
`endif
    case (state_q)
      S_IDLE: begin
        if (mem_valid && mem_sel) begin
          rdata_d = rd_word_w;
          if (|mem_wstrb) begin
            // Any strobe gives a full-word write.
            case (mem_addr[4:2])
              W_EDGE:  edge_clr_w = mem_wdata[N_INPUTS-1:0];
              W_IRQEN: irq_en_d   = mem_wdata[N_INPUTS-1:0];
`ifdef GPIO_FALLING_EDGE_EN
              W_FALL:  fall_clr_w = mem_wdata[N_INPUTS-1:0];
`endif
              default: ;
            endcase
          end
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Set wins over a same-cycle W1C.
  assign edge_d = (edge_q & ~edge_clr_w) | rise_w;
  // Interrupt is registered from current state: follows edge/enable by one
  // cycle.
  assign irq_d  = |(pend_w & irq_en_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      rdata_q  <= '0;
      edge_q   <= '0;
      irq_en_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdata_q  <= rdata_d;
      edge_q   <= edge_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
    end
  end

  assign mem_rdata = rdata_q;
  assign mem_ready = (state_q == S_RESP);
  assign irq       = irq_q;

  // Address byte-offset bits and upper store-data bits carry no meaning here.
  logic unused_bits;
  assign unused_bits = ^{mem_addr[1:0], mem_wdata};

endmodule
